full_adder: RTL and testbench

- One-bit full adder cell, the leaf of the 64-bit ripple-carry address adder and the ALU adders.
- Its primary path is purely combinational: sum and carry-out from a, b and carry-in, so 64 instances chain into a ripple adder with bit 0 carry-in tied to 0.
- A secondary clocked path registers the result and supports a bit-serial mode: a 64-bit add runs over 64 cycles using one cell plus an internal carry flop.

---
 rtl/full_adder_pkg.sv | 8 +
 rtl/full_adder_if.sv | 22 ++
 rtl/full_adder_comb.sv | 13 +
 rtl/full_adder.sv | 30 +++
 tb/tb_full_adder.sv | 123 ++++++++++++
 5 files changed

// File: rtl/full_adder_pkg.sv
// full_adder_pkg: shared width constant, carry-source type and majority helper for the adder cell.
package full_adder_pkg;
  localparam int DATA_W = 64;
  typedef enum logic {CIN_EXT, CIN_FLOP} cin_src_e;
  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction
endpackage

// File: rtl/full_adder_if.sv
// full_adder_if: operand, carry, control and result signals of one adder cell.
interface full_adder_if;
  logic a;
  logic b;
  logic Cin;
  logic sum;
  logic Cout;
  logic en;
  logic serial;
  logic start;
  logic sum_q;
  logic Cout_q;
  logic valid_q;
  modport master (
    output a, b, Cin, en, serial, start,
    input  sum, Cout, sum_q, Cout_q, valid_q
  );
  modport slave (
    input  a, b, Cin, en, serial, start,
    output sum, Cout, sum_q, Cout_q, valid_q
  );
endinterface

// File: rtl/full_adder_comb.sv
// full_adder_comb: pure combinational one-bit sum and carry-out.
module full_adder_comb
  import full_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = maj(a, b, cin);
endmodule

// File: rtl/full_adder.sv
// full_adder: combinational adder cell plus a registered path that can run bit-serial adds via its carry flop.
module full_adder
  import full_adder_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  full_adder_if.slave  bus
);
  cin_src_e src;
  logic cin_sel, s_r, c_r, sum_r, cout_r, valid_r;
  full_adder_comb u_comb (.a(bus.a), .b(bus.b), .cin(bus.Cin), .sum(bus.sum), .cout(bus.Cout));
  // Mid-stream serial bits take their carry from the flop; the first bit uses the external Cin.
  assign src     = (bus.serial && !bus.start) ? CIN_FLOP : CIN_EXT;
  assign cin_sel = (src == CIN_FLOP) ? cout_r : bus.Cin;
  full_adder_comb u_reg (.a(bus.a), .b(bus.b), .cin(cin_sel), .sum(s_r), .cout(c_r));
  always_ff @(posedge clk) begin
    if (!reset) begin
      sum_r   <= 1'b0;
      cout_r  <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      sum_r   <= bus.en ? s_r : sum_r;
      cout_r  <= bus.en ? c_r : cout_r;
      valid_r <= bus.en;
    end
  end
  assign bus.sum_q   = sum_r;
  assign bus.Cout_q  = cout_r;
  assign bus.valid_q = valid_r;
endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: directed checks of truth table, 64-bit ripple chain, registered and serial paths.
module tb_full_adder;
  import full_adder_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int tests = 0;
  int fails = 0;
  full_adder_if bus ();
  full_adder dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  logic [DATA_W-1:0] ra, rb, rs;
  logic [DATA_W:0] rc;
  assign rc[0] = 1'b0;
  for (genvar g = 0; g < DATA_W; g++) begin : g_rip
    full_adder_comb u_fa (.a(ra[g]), .b(rb[g]), .cin(rc[g]), .sum(rs[g]), .cout(rc[g+1]));
  end
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic serial_add(input logic [63:0] x, input logic [63:0] y, input int stall_at,
                            input int stall_len, input logic stall_carry,
                            output logic [63:0] res, output logic cout);
    res = '0;
    for (int k = 0; k < DATA_W; k++) begin
      if (k == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          bus.en = 1'b0;
          tick();
          check("stall_valid", 64'(bus.valid_q), 64'd0);
          check("stall_carry", 64'(bus.Cout_q), 64'(stall_carry));
        end
      end
      bus.en = 1'b1; bus.serial = 1'b1; bus.start = (k == 0); bus.Cin = 1'b0;
      bus.a = x[k]; bus.b = y[k];
      tick();
      res[k] = bus.sum_q;
    end
    cout = bus.Cout_q;
    bus.en = 1'b0;
  endtask
  logic [1:0] tt [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
  logic [63:0] res;
  logic co;
  initial begin
    bus.a = 1'b1; bus.b = 1'b1; bus.Cin = 1'b1; bus.en = 1'b1; bus.serial = 1'b0; bus.start = 1'b0;
    ra = '0; rb = '0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_sum_q", 64'(bus.sum_q), 64'd0);
      check("rst_cout_q", 64'(bus.Cout_q), 64'd0);
      check("rst_valid_q", 64'(bus.valid_q), 64'd0);
      check("rst_comb_sum", 64'(bus.sum), 64'd1);
      check("rst_comb_cout", 64'(bus.Cout), 64'd1);
    end
    reset = 1'b1;
    bus.en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      {bus.a, bus.b, bus.Cin} = v;
      #1;
      check("tt_sum", 64'(bus.sum), 64'(tt[i][0]));
      check("tt_cout", 64'(bus.Cout), 64'(tt[i][1]));
    end
    ra = 64'h7FFF_FFFF_FFFF_FFFF; rb = 64'd1; #1;
    check("rip_max_pos", rs, 64'h8000_0000_0000_0000);
    check("rip_max_pos_c", 64'(rc[DATA_W]), 64'd0);
    ra = 64'hFFFF_FFFF_FFFF_FFFF; rb = 64'd1; #1;
    check("rip_wrap", rs, 64'd0);
    check("rip_wrap_c", 64'(rc[DATA_W]), 64'd1);
    ra = 64'hFFFF_FFFF_FFFF_FFFF; rb = 64'hFFFF_FFFF_FFFF_FFFF; #1;
    check("rip_ones", rs, 64'hFFFF_FFFF_FFFF_FFFE);
    for (int i = 0; i < 10; i++) begin
      ra = 64'(i); rb = 64'(i + 1); #1;
      check("rip_seq", rs, 64'(2 * i + 1));
    end
    tick();
    bus.en = 1'b1; bus.serial = 1'b0; bus.start = 1'b0; bus.a = 1'b1; bus.b = 1'b0; bus.Cin = 1'b1;
    tick();
    check("cap_sum_q", 64'(bus.sum_q), 64'd0);
    check("cap_cout_q", 64'(bus.Cout_q), 64'd1);
    check("cap_valid_q", 64'(bus.valid_q), 64'd1);
    bus.en = 1'b0; bus.a = 1'b0; bus.Cin = 1'b0;
    tick();
    check("hold_sum_q", 64'(bus.sum_q), 64'd0);
    check("hold_cout_q", 64'(bus.Cout_q), 64'd1);
    check("hold_valid_q", 64'(bus.valid_q), 64'd0);
    serial_add(64'h7FFF_FFFF_FFFF_FFFF, 64'd2, -1, 0, 1'b0, res, co);
    check("ser_a_sum", res, 64'h8000_0000_0000_0001);
    check("ser_a_cout", 64'(co), 64'd0);
    serial_add(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, -1, 0, 1'b0, res, co);
    check("ser_b_sum", res, 64'h7FFF_FFFF_FFFF_FFFF);
    check("ser_b_cout", 64'(co), 64'd1);
    serial_add(64'h7FFF_FFFF_FFFF_FFFF, 64'd2, 10, 3, 1'b1, res, co);
    check("stall_sum", res, 64'h8000_0000_0000_0001);
    check("stall_cout", 64'(co), 64'd0);
    for (int k = 0; k < 20; k++) begin
      bus.en = 1'b1; bus.serial = 1'b1; bus.start = (k == 0); bus.Cin = 1'b0;
      bus.a = (k < 63); bus.b = (k == 1);
      tick();
    end
    check("abort_pre_cout", 64'(bus.Cout_q), 64'd1);
    reset = 1'b0;
    tick();
    check("abort_cout_q", 64'(bus.Cout_q), 64'd0);
    check("abort_sum_q", 64'(bus.sum_q), 64'd0);
    check("abort_valid_q", 64'(bus.valid_q), 64'd0);
    reset = 1'b1;
    serial_add(64'h7FFF_FFFF_FFFF_FFFF, 64'd2, -1, 0, 1'b0, res, co);
    check("restart_sum", res, 64'h8000_0000_0000_0001);
    check("restart_cout", 64'(co), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
